// File: rtl/dual_port_ram_4096x64.sv
// Simple dual-port RAM, one write and one read port on a single clock.
// Words never written since the last reset read back as zero; same-address read/write is write-first.
module dual_port_ram_4096x64 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_BYP  = 2'd2
    } src_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid_reg;
    logic [DATA_WIDTH-1:0] mem_rd_reg;
    logic [DATA_WIDTH-1:0] byp_reg;
    src_t                  src_reg;
    src_t                  src_next;

    // Storage has no reset; stale contents are masked by the valid bitmap.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_address] <= data_in;
        end
    end

    // Registered array read kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (read) begin
            mem_rd_reg <= mem[rd_address];
            byp_reg    <= data_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= '0;
        end else if (write) begin
            valid_reg[wr_address] <= 1'b1;
        end
    end

    always_comb begin
        src_next = src_reg;
        if (read) begin
            if (write && (wr_address == rd_address)) begin
                src_next = SRC_BYP;
            end else if (valid_reg[rd_address]) begin
                src_next = SRC_MEM;
            end else begin
                src_next = SRC_ZERO;
            end
        end
    end

    // Selecting zero on reset clears the output at once without touching the data registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_reg <= SRC_ZERO;
        end else begin
            src_reg <= src_next;
        end
    end

    always_comb begin
        data_out = '0;
        case (src_reg)
            SRC_MEM: data_out = mem_rd_reg;
            SRC_BYP: data_out = byp_reg;
            default: data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_dual_port_ram_4096x64.sv
// Randomised scoreboard bench for dual_port_ram_4096x64 against an associative-array memory model.
module tb_dual_port_ram_4096x64;

    logic        clk;
    logic        resetn;
    logic [63:0] data_in;
    logic [11:0] wr_address;
    logic        write;
    logic [11:0] rd_address;
    logic        read;
    logic [63:0] data_out;

    dual_port_ram_4096x64 dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .wr_address (wr_address),
        .write      (write),
        .rd_address (rd_address),
        .read       (read),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [$];
    logic        mon_en = 1'b0;

    logic [63:0] model_mem [int];
    logic [63:0] exp_dout = 64'h0;

    // One expected data_out value per rising edge, popped just after that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow t=%0t data_out=%h", $time, data_out);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        errors++;
                        $display("FAIL dout t=%0t got %h expected %h", $time, data_out, e);
                    end
                end
            end
        end
    end

    // Drive one cycle at a falling edge and record what data_out must be after the next rising edge.
    task automatic cycle(input logic w, input logic [11:0] wa, input logic [63:0] wd,
                         input logic r, input logic [11:0] ra);
        write      = w;
        wr_address = wa;
        data_in    = wd;
        read       = r;
        rd_address = ra;
        if (resetn) begin
            if (r) begin
                if (w && wa == ra)
                    exp_dout = wd;
                else if (model_mem.exists(int'(ra)))
                    exp_dout = model_mem[int'(ra)];
                else
                    exp_dout = 64'h0;
            end
            if (w) model_mem[int'(wa)] = wd;
        end else begin
            exp_dout = 64'h0;
        end
        exp_q.push_back(exp_dout);
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic direct_check(input string name, input logic [63:0] want);
        checks++;
        if (data_out !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, data_out, want);
        end
    endtask

    // Assert reset away from the rising edge, check the immediate clear, release a cycle later.
    task automatic reset_pulse();
        #2;
        resetn = 1'b0;
        #1;
        direct_check("reset_immediate", 64'h0);
        model_mem.delete();
        cycle(1'b1, 12'h123, {$urandom, $urandom}, 1'b1, 12'h123);
        resetn = 1'b1;
    endtask

    initial begin
        write = 1'b0; read = 1'b0; data_in = '0; wr_address = '0; rd_address = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        direct_check("power_on_reset", 64'h0);
        resetn = 1'b1;

        // Load a recognisable value onto data_out, then reset mid-cycle.
        cycle(1'b1, 12'h321, 64'hDEAD_BEEF_0000_0001, 1'b0, 12'h0);
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h321);
        cycle(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
        reset_pulse();
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h321);
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h123);

        // Boundary addresses.
        cycle(1'b1, 12'h000, 64'h0123_4567_89AB_CDEF, 1'b0, 12'h0);
        cycle(1'b1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 12'h0);
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h000);
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'hFFF);

        // Same-address collision is write-first.
        cycle(1'b1, 12'h555, 64'h1, 1'b0, 12'h0);
        cycle(1'b1, 12'h555, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 12'h555);
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h555);

        // Streaming write N / read N-1 every cycle.
        for (int n = 1; n < 4096; n++)
            cycle(1'b1, 12'(n), 64'(n * 3), 1'b1, 12'(n - 1));
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'hFFF);

        // Hold with read low while the read address wanders.
        cycle(1'b1, 12'h010, 64'h77, 1'b0, 12'h0);
        cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h010);
        for (int k = 0; k < 5; k++)
            cycle(1'b0, 12'h0, 64'h0, 1'b0, 12'($urandom));

        // Random traffic with a reset in the middle; a narrow address window forces hits.
        for (int t = 0; t < 5000; t++) begin
            logic [11:0] wa, ra;
            if (t == 2500) reset_pulse();
            wa = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
            cycle(1'($urandom), wa, {$urandom, $urandom}, 1'($urandom), ra);
        end

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
